usb3_proto_rx_engine: RTL and testbench

USB3_PROTO_RX_ENGINE -- requirements
Module: usb3_proto_rx_engine

---
 rtl/usb3_proto_pkg.sv | 35 +++
 rtl/usb3_seq_table.sv | 41 ++++
 rtl/usb3_proto_rx_engine.sv | 277 +++++++++++++++++++++++++++
 tb/tb_usb3_proto_rx_engine.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb3_proto_pkg.sv
// Shared definitions for the USB3 protocol-layer receive path: FSM states,
// TP subtype codes, retry/direction constants and sequence-number width.
package usb3_proto_pkg;

  localparam int SEQ_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_WAIT_DONE  = 3'd2,
    ST_SEND_ACK   = 3'd3,
    ST_TP_DECODE  = 3'd4
  } rx_state_t;

  localparam logic [3:0] TP_ACK        = 4'd1;
  localparam logic [3:0] TP_NRDY       = 4'd2;
  localparam logic [3:0] TP_ERDY       = 4'd3;
  localparam logic [3:0] TP_STATUS     = 4'd4;
  localparam logic [3:0] TP_STALL      = 4'd5;
  localparam logic [3:0] TP_DEV_NOTIFY = 4'd6;
  localparam logic [3:0] TP_PING       = 4'd7;
  localparam logic [3:0] TP_PING_RSP   = 4'd8;

  localparam logic RETRY_NONE = 1'b0;
  localparam logic RETRY_REQ  = 1'b1;

  localparam logic DIR_OUT = 1'b0;
  localparam logic DIR_IN  = 1'b1;

  // Sequence numbers live in a 5-bit space and wrap 31 -> 0.
  function automatic logic [SEQ_W-1:0] seq_next(input logic [SEQ_W-1:0] s);
    return s + SEQ_W'(1);
  endfunction

endpackage

// File: rtl/usb3_seq_table.sv
// Per-endpoint expected sequence numbers with one read port, one increment
// port, a single-endpoint clear (SETUP) and a per-endpoint reset vector.
module usb3_seq_table
  import usb3_proto_pkg::*;
#(
  parameter int NUM_EP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        rd_endp,
  output logic [SEQ_W-1:0]  rd_seq,
  input  logic              inc_en,
  input  logic [3:0]        inc_endp,
  input  logic              clr_en,
  input  logic [3:0]        clr_endp,
  input  logic [NUM_EP-1:0] seq_reset
);

  logic [SEQ_W-1:0] seq_q [NUM_EP];

  // Clearing (reset vector or SETUP) takes precedence over an increment.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_EP; i++) begin
      if (reset) begin
        seq_q[i] <= '0;
      end else if (seq_reset[i] || (clr_en && clr_endp == 4'(i))) begin
        seq_q[i] <= '0;
      end else if (inc_en && inc_endp == 4'(i)) begin
        seq_q[i] <= seq_next(seq_q[i]);
      end
    end
  end

  always_comb begin
    rd_seq = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (rd_endp == 4'(i)) rd_seq = seq_q[i];
    end
  end

endmodule

// File: rtl/usb3_proto_rx_engine.sv
// USB3 protocol-layer RX engine: DPH/DPP tracking, ACK generation, TP decode
// and IN-request hand-off. Optional error counters under USB3_PROTO_ERR_CNT_EN.
module usb3_proto_rx_engine
  import usb3_proto_pkg::*;
#(
  parameter int NUM_EP        = 4,
  parameter int DPP_START_TMO = 20,
  parameter int DPP_DONE_TMO  = 270,
  parameter int TMO_W         = 10
) (
  input  logic              local_clk,
  input  logic              reset,
  input  logic              ltssm_u0,
  input  logic              rx_dph,
  input  logic [3:0]        rx_dph_endp,
  input  logic [4:0]        rx_dph_seq,
  input  logic              rx_dph_setup,
  input  logic              rx_dpp_start,
  input  logic              rx_dpp_done,
  input  logic              rx_dpp_crcgood,
  input  logic              rx_tp,
  input  logic [3:0]        rx_tp_subtype,
  input  logic [3:0]        rx_tp_endp,
  input  logic [4:0]        rx_tp_nump,
  input  logic [4:0]        rx_tp_seq,
  input  logic              rx_tp_pktpend,
  input  logic [NUM_EP-1:0] seq_reset,
  output logic              ack_valid,
  input  logic              ack_ready,
  output logic              ack_retry,
  output logic [3:0]        ack_endp,
  output logic [4:0]        ack_nump,
  output logic [4:0]        ack_seq,
  output logic              in_req_valid,
  input  logic              in_req_ready,
  output logic [3:0]        in_req_endp,
  output logic [4:0]        in_req_nump,
  output logic [4:0]        in_req_seq,
  output logic [3:0]        sel_endp,
  output logic              err_miss_rx,
  output logic              err_start_tmo,
  output logic              err_done_tmo,
  output logic              err_bad_endp,
  output logic              err_tp_subtype
`ifdef USB3_PROTO_ERR_CNT_EN
  ,
  output logic [5*16-1:0]   err_cnt
`endif
);

  localparam logic [4:0]       NUM_EP_L  = 5'(NUM_EP);
  localparam logic [TMO_W-1:0] START_LIM = TMO_W'(DPP_START_TMO);
  localparam logic [TMO_W-1:0] DONE_LIM  = TMO_W'(DPP_DONE_TMO);

  rx_state_t        state_q, state_d;
  logic [TMO_W-1:0] cnt_q;
  logic [3:0]       endp_q;
  logic [4:0]       seq_q;
  logic [3:0]       tp_sub_q;
  logic [4:0]       tp_nump_q;
  logic [4:0]       tp_seq_q;
  logic             tp_pktpend_q;

  logic             dph_accept, tp_accept, load_ack, load_in_req, inc_en;
  logic             ack_retry_d;
  logic [4:0]       ack_nump_d, ack_seq_d;
  logic             ev_miss, ev_start, ev_done, ev_bad, ev_sub;
  logic             good;
  logic [SEQ_W-1:0] rd_seq, seq_kept;
  logic [15:0]      seq_reset_ext;

  assign seq_reset_ext = 16'(seq_reset);
  assign ack_valid     = (state_q == ST_SEND_ACK);

  usb3_seq_table #(.NUM_EP(NUM_EP)) u_seq_table (
    .clk       (local_clk),
    .reset     (reset),
    .rd_endp   (endp_q),
    .rd_seq    (rd_seq),
    .inc_en    (inc_en),
    .inc_endp  (endp_q),
    .clr_en    (dph_accept && rx_dph_setup),
    .clr_endp  (rx_dph_endp),
    .seq_reset (seq_reset)
  );

  always_ff @(posedge local_clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ACK seq reports the table value as it will be after this cycle's update,
  // so a coincident seq_reset on the endpoint is folded in here as well.
  always_comb begin
    state_d     = state_q;
    dph_accept  = 1'b0;
    tp_accept   = 1'b0;
    load_ack    = 1'b0;
    load_in_req = 1'b0;
    inc_en      = 1'b0;
    ack_retry_d = RETRY_NONE;
    ack_nump_d  = 5'd1;
    ack_seq_d   = '0;
    ev_miss     = 1'b0;
    ev_start    = 1'b0;
    ev_done     = 1'b0;
    ev_bad      = 1'b0;
    ev_sub      = 1'b0;
    good        = rx_dpp_crcgood && (seq_q == rd_seq);
    seq_kept    = seq_reset_ext[endp_q] ? '0 : rd_seq;

    case (state_q)
      ST_IDLE: begin
        if (rx_dph) begin
          if (rx_tp) ev_miss = 1'b1;
          if ({1'b0, rx_dph_endp} < NUM_EP_L) begin
            dph_accept = 1'b1;
            state_d    = ST_WAIT_START;
          end else begin
            ev_bad = 1'b1;
          end
        end else if (rx_tp) begin
          tp_accept = 1'b1;
          state_d   = ST_TP_DECODE;
        end
      end

      ST_WAIT_START: begin
        if (!ltssm_u0) begin
          state_d = ST_IDLE;
        end else if (rx_dpp_start) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == START_LIM) begin
          ev_start    = 1'b1;
          load_ack    = 1'b1;
          ack_retry_d = RETRY_REQ;
          ack_seq_d   = seq_kept;
          state_d     = ST_SEND_ACK;
        end
      end

      ST_WAIT_DONE: begin
        if (!ltssm_u0) begin
          state_d = ST_IDLE;
        end else if (rx_dpp_done) begin
          load_ack = 1'b1;
          state_d  = ST_SEND_ACK;
          if (good) begin
            inc_en      = 1'b1;
            ack_retry_d = RETRY_NONE;
            ack_seq_d   = seq_reset_ext[endp_q] ? '0 : seq_next(rd_seq);
          end else begin
            ack_retry_d = RETRY_REQ;
            ack_seq_d   = seq_kept;
          end
        end else if (cnt_q == DONE_LIM) begin
          ev_done     = 1'b1;
          load_ack    = 1'b1;
          ack_retry_d = RETRY_REQ;
          ack_seq_d   = seq_kept;
          state_d     = ST_SEND_ACK;
        end
      end

      ST_SEND_ACK: begin
        if (ack_ready) state_d = ST_IDLE;
      end

      ST_TP_DECODE: begin
        state_d = ST_IDLE;
        case (tp_sub_q)
          TP_ACK: begin
            if (tp_pktpend_q && tp_nump_q != 5'd0) begin
              if (in_req_valid) ev_miss = 1'b1;
              else              load_in_req = 1'b1;
            end
          end
          TP_STATUS: begin
            load_ack    = 1'b1;
            ack_retry_d = RETRY_NONE;
            ack_nump_d  = 5'd0;
            ack_seq_d   = seq_kept;
            state_d     = ST_SEND_ACK;
          end
          TP_NRDY, TP_ERDY, TP_PING: ;
          default: ev_sub = 1'b1;
        endcase
      end

      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && (rx_dph || rx_tp)) ev_miss = 1'b1;
  end

  always_ff @(posedge local_clk) begin
    if (reset) begin
      cnt_q          <= '0;
      endp_q         <= '0;
      seq_q          <= '0;
      tp_sub_q       <= '0;
      tp_nump_q      <= '0;
      tp_seq_q       <= '0;
      tp_pktpend_q   <= 1'b0;
      sel_endp       <= '0;
      ack_retry      <= 1'b0;
      ack_endp       <= '0;
      ack_nump       <= '0;
      ack_seq        <= '0;
      in_req_valid   <= 1'b0;
      in_req_endp    <= '0;
      in_req_nump    <= '0;
      in_req_seq     <= '0;
      err_miss_rx    <= 1'b0;
      err_start_tmo  <= 1'b0;
      err_done_tmo   <= 1'b0;
      err_bad_endp   <= 1'b0;
      err_tp_subtype <= 1'b0;
    end else begin
      if (dph_accept) begin
        endp_q   <= rx_dph_endp;
        seq_q    <= rx_dph_seq;
        sel_endp <= rx_dph_endp;
        cnt_q    <= '0;
      end else if (state_q == ST_WAIT_START || state_q == ST_WAIT_DONE) begin
        cnt_q <= cnt_q + TMO_W'(1);
      end

      if (tp_accept) begin
        endp_q       <= rx_tp_endp;
        tp_sub_q     <= rx_tp_subtype;
        tp_nump_q    <= rx_tp_nump;
        tp_seq_q     <= rx_tp_seq;
        tp_pktpend_q <= rx_tp_pktpend;
      end

      if (load_ack) begin
        ack_retry <= ack_retry_d;
        ack_endp  <= endp_q;
        ack_nump  <= ack_nump_d;
        ack_seq   <= ack_seq_d;
      end

      if (load_in_req) begin
        in_req_valid <= 1'b1;
        in_req_endp  <= endp_q;
        in_req_nump  <= tp_nump_q;
        in_req_seq   <= tp_seq_q;
      end else if (in_req_valid && in_req_ready) begin
        in_req_valid <= 1'b0;
      end

      if (ev_miss)  err_miss_rx    <= 1'b1;
      if (ev_start) err_start_tmo  <= 1'b1;
      if (ev_done)  err_done_tmo   <= 1'b1;
      if (ev_bad)   err_bad_endp   <= 1'b1;
      if (ev_sub)   err_tp_subtype <= 1'b1;
    end
  end

`ifdef USB3_PROTO_ERR_CNT_EN
  logic [4:0]  ev_vec;
  logic [15:0] cnt_arr [5];

  assign ev_vec  = {ev_sub, ev_bad, ev_done, ev_start, ev_miss};
  assign err_cnt = {cnt_arr[4], cnt_arr[3], cnt_arr[2], cnt_arr[1], cnt_arr[0]};

  // Counters stop at all-ones rather than wrapping back to zero.
  always_ff @(posedge local_clk) begin
    for (int i = 0; i < 5; i++) begin
      if (reset)                                    cnt_arr[i] <= '0;
      else if (ev_vec[i] && cnt_arr[i] != 16'hFFFF) cnt_arr[i] <= cnt_arr[i] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_usb3_proto_rx_engine.sv
// Scoreboard bench for usb3_proto_rx_engine: expected ACKs and IN requests
// are queued when stimulus is driven and compared when the DUT hands them off.
module tb_usb3_proto_rx_engine;

  localparam int         NUM_EP     = 4;
  localparam logic [3:0] T_ACK      = 4'd1;
  localparam logic [3:0] T_NRDY     = 4'd2;
  localparam logic [3:0] T_STATUS   = 4'd4;
  localparam logic [3:0] T_PING     = 4'd7;
  localparam logic [3:0] T_BAD      = 4'hF;

  typedef struct packed {
    logic       retry;
    logic [3:0] endp;
    logic [4:0] nump;
    logic [4:0] seq;
  } ack_t;

  typedef struct packed {
    logic [3:0] endp;
    logic [4:0] nump;
    logic [4:0] seq;
  } inreq_t;

  logic local_clk, reset, ltssm_u0;
  logic rx_dph, rx_dph_setup, rx_dpp_start, rx_dpp_done, rx_dpp_crcgood;
  logic [3:0] rx_dph_endp;
  logic [4:0] rx_dph_seq;
  logic rx_tp, rx_tp_pktpend;
  logic [3:0] rx_tp_subtype, rx_tp_endp;
  logic [4:0] rx_tp_nump, rx_tp_seq;
  logic [NUM_EP-1:0] seq_reset;
  logic ack_valid, ack_ready, ack_retry;
  logic [3:0] ack_endp;
  logic [4:0] ack_nump, ack_seq;
  logic in_req_valid, in_req_ready;
  logic [3:0] in_req_endp;
  logic [4:0] in_req_nump, in_req_seq;
  logic [3:0] sel_endp;
  logic err_miss_rx, err_start_tmo, err_done_tmo, err_bad_endp, err_tp_subtype;
`ifdef USB3_PROTO_ERR_CNT_EN
  logic [79:0] err_cnt;
`endif

  ack_t       ack_q [$];
  inreq_t     inq [$];
  ack_t       mon_ack;
  inreq_t     mon_req;
  logic [4:0] exp_seq [16];
  logic       tp_with_dph;
  int         checks;
  int         errors;

  usb3_proto_rx_engine #(
    .NUM_EP(NUM_EP), .DPP_START_TMO(20), .DPP_DONE_TMO(270), .TMO_W(10)
  ) dut (
    .local_clk      (local_clk),
    .reset          (reset),
    .ltssm_u0       (ltssm_u0),
    .rx_dph         (rx_dph),
    .rx_dph_endp    (rx_dph_endp),
    .rx_dph_seq     (rx_dph_seq),
    .rx_dph_setup   (rx_dph_setup),
    .rx_dpp_start   (rx_dpp_start),
    .rx_dpp_done    (rx_dpp_done),
    .rx_dpp_crcgood (rx_dpp_crcgood),
    .rx_tp          (rx_tp),
    .rx_tp_subtype  (rx_tp_subtype),
    .rx_tp_endp     (rx_tp_endp),
    .rx_tp_nump     (rx_tp_nump),
    .rx_tp_seq      (rx_tp_seq),
    .rx_tp_pktpend  (rx_tp_pktpend),
    .seq_reset      (seq_reset),
    .ack_valid      (ack_valid),
    .ack_ready      (ack_ready),
    .ack_retry      (ack_retry),
    .ack_endp       (ack_endp),
    .ack_nump       (ack_nump),
    .ack_seq        (ack_seq),
    .in_req_valid   (in_req_valid),
    .in_req_ready   (in_req_ready),
    .in_req_endp    (in_req_endp),
    .in_req_nump    (in_req_nump),
    .in_req_seq     (in_req_seq),
    .sel_endp       (sel_endp),
    .err_miss_rx    (err_miss_rx),
    .err_start_tmo  (err_start_tmo),
    .err_done_tmo   (err_done_tmo),
    .err_bad_endp   (err_bad_endp),
    .err_tp_subtype (err_tp_subtype)
`ifdef USB3_PROTO_ERR_CNT_EN
    ,
    .err_cnt        (err_cnt)
`endif
  );

  initial local_clk = 1'b0;
  always #5 local_clk = ~local_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Handshakes complete on the next rising edge; sample on the falling edge.
  always @(negedge local_clk) begin
    if (!reset && ack_valid && ack_ready) begin
      if (ack_q.size() == 0) begin
        checkOutput("ack_unexpected", 32'(ack_valid), 32'd0);
      end else begin
        mon_ack = ack_q.pop_front();
        checkOutput("ack_retry", 32'(ack_retry), 32'(mon_ack.retry));
        checkOutput("ack_endp",  32'(ack_endp),  32'(mon_ack.endp));
        checkOutput("ack_nump",  32'(ack_nump),  32'(mon_ack.nump));
        checkOutput("ack_seq",   32'(ack_seq),   32'(mon_ack.seq));
      end
    end
    if (!reset && in_req_valid && in_req_ready) begin
      if (inq.size() == 0) begin
        checkOutput("inreq_unexpected", 32'(in_req_valid), 32'd0);
      end else begin
        mon_req = inq.pop_front();
        checkOutput("inreq_endp", 32'(in_req_endp), 32'(mon_req.endp));
        checkOutput("inreq_nump", 32'(in_req_nump), 32'(mon_req.nump));
        checkOutput("inreq_seq",  32'(in_req_seq),  32'(mon_req.seq));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge local_clk);
    #1;
  endtask

  task automatic clearInputs();
    rx_dph = 1'b0; rx_dph_endp = '0; rx_dph_seq = '0; rx_dph_setup = 1'b0;
    rx_dpp_start = 1'b0; rx_dpp_done = 1'b0; rx_dpp_crcgood = 1'b0;
    rx_tp = 1'b0; rx_tp_subtype = '0; rx_tp_endp = '0; rx_tp_nump = '0;
    rx_tp_seq = '0; rx_tp_pktpend = 1'b0; seq_reset = '0;
  endtask

  task automatic doReset();
    reset = 1'b1; ltssm_u0 = 1'b1; ack_ready = 1'b1; in_req_ready = 1'b1;
    clearInputs();
    tick(3);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) exp_seq[i] = '0;
    ack_q.delete();
    inq.delete();
    tick(1);
  endtask

  task automatic drainQueues(input int bound);
    int n = 0;
    while ((ack_q.size() != 0 || inq.size() != 0) && n < bound) begin
      tick(1);
      n++;
    end
    checkOutput("drain_ack",   32'(ack_q.size()), 32'd0);
    checkOutput("drain_inreq", 32'(inq.size()),   32'd0);
    ack_q.delete();
    inq.delete();
  endtask

  // One data packet: DPH, then DPP start/done pulses start_dly/done_dly cycles
  // later (0 means the pulse never comes, forcing a timeout).
  task automatic applyStimulus(input logic [3:0] endp, input logic [4:0] seq,
                               input logic setup, input int start_dly,
                               input int done_dly, input logic crc,
                               input logic rst_at_done);
    ack_t e;
    logic good;
    int   last;
    if (setup) exp_seq[endp] = '0;
    e.endp = endp;
    e.nump = 5'd1;
    if (start_dly == 0 || done_dly == 0) begin
      e.retry = 1'b1;
      e.seq   = exp_seq[endp];
    end else begin
      good = crc && (seq == exp_seq[endp]);
      if (rst_at_done) exp_seq[endp] = '0;
      else if (good)   exp_seq[endp] = exp_seq[endp] + 5'd1;
      e.retry = !good;
      e.seq   = exp_seq[endp];
    end
    ack_q.push_back(e);

    rx_dph = 1'b1; rx_dph_endp = endp; rx_dph_seq = seq; rx_dph_setup = setup;
    rx_tp = tp_with_dph;
    tick(1);
    rx_dph = 1'b0; rx_dph_setup = 1'b0; rx_tp = 1'b0;
    last = (start_dly > done_dly) ? start_dly : done_dly;
    for (int c = 1; c <= last; c++) begin
      rx_dpp_start   = (c == start_dly);
      rx_dpp_done    = (c == done_dly);
      rx_dpp_crcgood = (c == done_dly) && crc;
      seq_reset      = (rst_at_done && c == done_dly) ? NUM_EP'(4'(1) << endp) : '0;
      tick(1);
    end
    clearInputs();
    drainQueues(400);
    checkOutput("sel_endp", 32'(sel_endp), 32'(endp));
  endtask

  task automatic sendTp(input logic [3:0] sub, input logic [3:0] endp,
                        input logic [4:0] nump, input logic [4:0] seq,
                        input logic pktpend);
    ack_t   e;
    inreq_t r;
    if (sub == T_STATUS) begin
      e.retry = 1'b0; e.endp = endp; e.nump = 5'd0; e.seq = exp_seq[endp];
      ack_q.push_back(e);
    end else if (sub == T_ACK && pktpend && nump != 5'd0 && inq.size() == 0) begin
      r.endp = endp; r.nump = nump; r.seq = seq;
      inq.push_back(r);
    end
    rx_tp = 1'b1; rx_tp_subtype = sub; rx_tp_endp = endp;
    rx_tp_nump = nump; rx_tp_seq = seq; rx_tp_pktpend = pktpend;
    tick(1);
    rx_tp = 1'b0;
    tick(1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tp_with_dph = 1'b0;
    doReset();

    checkOutput("rst_ack_valid",   32'(ack_valid),    32'd0);
    checkOutput("rst_inreq_valid", 32'(in_req_valid), 32'd0);
    checkOutput("rst_sel_endp",    32'(sel_endp),     32'd0);
    checkOutput("rst_ack_payload", 32'({ack_retry, ack_endp, ack_nump, ack_seq}), 32'd0);
    checkOutput("rst_inreq_payload", 32'({in_req_endp, in_req_nump, in_req_seq}), 32'd0);
    checkOutput("rst_errs", 32'({err_miss_rx, err_start_tmo, err_done_tmo,
                                 err_bad_endp, err_tp_subtype}), 32'd0);

    applyStimulus(4'd1, 5'd0, 1'b0, 3, 40, 1'b1, 1'b0);

    for (int i = 0; i < 32; i++) applyStimulus(4'd2, 5'(i), 1'b0, 1, 3, 1'b1, 1'b0);
    checkOutput("wrap_final_seq", 32'(ack_seq), 32'd0);

    applyStimulus(4'd0, 5'd4, 1'b0, 2, 5, 1'b1, 1'b0);
    applyStimulus(4'd0, 5'd0, 1'b1, 2, 5, 1'b1, 1'b0);
    applyStimulus(4'd3, 5'd0, 1'b0, 2, 5, 1'b0, 1'b0);

    sendTp(T_STATUS, 4'd1, 5'd0, 5'd0, 1'b0);
    drainQueues(20);
    sendTp(T_NRDY, 4'd1, 5'd0, 5'd0, 1'b0);
    sendTp(T_PING, 4'd2, 5'd0, 5'd0, 1'b0);
    tick(2);
    checkOutput("no_err_yet", 32'({err_miss_rx, err_start_tmo, err_done_tmo,
                                   err_bad_endp, err_tp_subtype}), 32'd0);

    applyStimulus(4'd1, 5'd1, 1'b0, 0, 0, 1'b1, 1'b0);
    checkOutput("err_start_tmo", 32'(err_start_tmo), 32'd1);
    checkOutput("err_done_tmo_quiet", 32'(err_done_tmo), 32'd0);
    applyStimulus(4'd1, 5'd1, 1'b0, 2, 0, 1'b1, 1'b0);
    checkOutput("err_done_tmo", 32'(err_done_tmo), 32'd1);

    rx_dph = 1'b1; rx_dph_endp = 4'd5; rx_dph_seq = 5'd0;
    tick(1);
    rx_dph = 1'b0;
    tick(3);
    checkOutput("err_bad_endp", 32'(err_bad_endp), 32'd1);
    checkOutput("bad_endp_no_ack", 32'(ack_valid), 32'd0);

    sendTp(T_BAD, 4'd0, 5'd0, 5'd0, 1'b0);
    tick(1);
    checkOutput("err_tp_subtype", 32'(err_tp_subtype), 32'd1);
    checkOutput("err_miss_rx_quiet", 32'(err_miss_rx), 32'd0);

    doReset();
    checkOutput("rst2_errs", 32'({err_miss_rx, err_start_tmo, err_done_tmo,
                                  err_bad_endp, err_tp_subtype}), 32'd0);

    in_req_ready = 1'b0;
    sendTp(T_ACK, 4'd1, 5'd2, 5'd3, 1'b1);
    tick(1);
    for (int c = 0; c < 10; c++) begin
      checkOutput("inreq_hold_valid", 32'(in_req_valid), 32'd1);
      checkOutput("inreq_hold_fields", 32'({in_req_endp, in_req_nump, in_req_seq}),
                  32'({4'd1, 5'd2, 5'd3}));
      if (c == 4) begin
        checkOutput("miss_before_2nd", 32'(err_miss_rx), 32'd0);
        sendTp(T_ACK, 4'd2, 5'd1, 5'd7, 1'b1);
      end else begin
        tick(1);
      end
    end
    checkOutput("err_miss_rx_inreq", 32'(err_miss_rx), 32'd1);
    in_req_ready = 1'b1;
    drainQueues(20);
    tick(2);
    checkOutput("inreq_released", 32'(in_req_valid), 32'd0);

    doReset();
    applyStimulus(4'd1, 5'd0, 1'b0, 1, 3, 1'b1, 1'b0);
    rx_dph = 1'b1; rx_dph_endp = 4'd1; rx_dph_seq = 5'd1;
    tick(1);
    rx_dph = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      rx_dpp_start = (c == 2);
      ltssm_u0     = (c != 5);
      tick(1);
    end
    clearInputs();
    ltssm_u0 = 1'b1;
    tick(3);
    checkOutput("abort_no_ack", 32'(ack_valid), 32'd0);
    checkOutput("abort_no_tmo", 32'({err_start_tmo, err_done_tmo}), 32'd0);
    applyStimulus(4'd1, 5'd1, 1'b0, 1, 3, 1'b1, 1'b0);
    applyStimulus(4'd1, 5'd2, 1'b0, 1, 3, 1'b1, 1'b1);
    applyStimulus(4'd1, 5'd0, 1'b0, 1, 3, 1'b1, 1'b0);

    tp_with_dph = 1'b1;
    applyStimulus(4'd3, 5'd0, 1'b0, 1, 3, 1'b1, 1'b0);
    tp_with_dph = 1'b0;
    checkOutput("err_miss_rx_dual", 32'(err_miss_rx), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
